async_fifo: RTL and testbench

// - Synchronous-interface FIFO buffer between a byte producer and consumer
//   in the I2C datapath; one clock domain, first-in first-out ordering.
// - Registered read data, registered full/empty flags, overflow/underflow

---
 rtl/async_fifo.sv | 110 +++++++++++
 tb/tb_async_fifo.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// ---------------------------------------------------------------------------
// async_fifo
// Single-clock FIFO buffer between a byte producer and a byte consumer in the
// I2C datapath. Read data and both status flags are registered. A write to a
// full FIFO or a read from an empty FIFO is dropped and leaves all state
// untouched.
//
// Parameters
//   DATA_WIDTH  width of din/dout in bits
//   DEPTH       number of entries (power of two, >= 2)
//
// Ports
//   clk    in   rising-edge clock for all state
//   rst_n  in   asynchronous active-low reset
//   wr_en  in   write request, accepted when the FIFO is not full
//   rd_en  in   read request, accepted when the FIFO is not empty
//   din    in   write data, captured with an accepted write
//   dout   out  read data register, updated by an accepted read
//   full   out  FIFO holds DEPTH entries
//   empty  out  FIFO holds no entries
// ---------------------------------------------------------------------------
module async_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int ADDR_W = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so that full and empty can be told
   // apart when the index bits are equal.
   localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

   logic [ADDR_W:0]         wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]         rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0]   dout_q, dout_d;
   logic                    full_q, full_d;
   logic                    empty_q, empty_d;
   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic                    wr_accept;
   logic                    rd_accept;

   // Acceptance is judged on the registered flags, so a simultaneous
   // read/write on a full FIFO only reads, and on an empty FIFO only writes.
   assign wr_accept = wr_en && !full_q;
   assign rd_accept = rd_en && !empty_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so that no
      // path leaves it unassigned, which would infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      dout_d   = dout_q;

      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         dout_d   = mem_q[rd_ptr_q[ADDR_W-1:0]];
      end

      // Flags come from the next-state pointers so they line up with the
      // pointer registers in the same cycle.
      empty_d = (wr_ptr_d == rd_ptr_d);
      full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
   end

   // NOTE: sequential state is updated with non-blocking assignments so all
   // registers sample their inputs from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         dout_q   <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         dout_q   <= dout_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // NOTE: the storage array is deliberately left out of reset; the
   // pointers alone define which entries are valid, and an unreset array
   // maps onto plain flops or RAM without a reset tree.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= din;
      end
   end

   assign dout  = dout_q;
   assign full  = full_q;
   assign empty = empty_q;

endmodule

// File: tb/tb_async_fifo.sv
// ---------------------------------------------------------------------------
// tb_async_fifo
// Directed testbench for async_fifo. Written data is pushed onto a scoreboard
// queue when an accepted write is driven and popped when the FIFO is expected
// to return it; the expected flags come from the scoreboard occupancy.
// ---------------------------------------------------------------------------
module tb_async_fifo;

   localparam int DATA_WIDTH = 8;
   localparam int DEPTH      = 16;

   logic                  clk;
   logic                  rst_n;
   logic                  wr_en;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic                  full;
   logic                  empty;

   async_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_en (wr_en),
      .rd_en (rd_en),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int                    n_vectors = 0;
   int                    n_miscompares = 0;
   logic [DATA_WIDTH-1:0] sb_q [$];
   logic [DATA_WIDTH-1:0] exp_dout = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vectors++;
      assert (obs === exp) else begin
         n_miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, " dout"},  32'(dout),  32'(exp_dout));
      check({tag, " full"},  32'(full),  32'(sb_q.size() == DEPTH));
      check({tag, " empty"}, 32'(empty), 32'(sb_q.size() == 0));
   endtask

   // One clock of stimulus: drive on the falling edge, update the model with
   // the pre-edge occupancy, check just after the rising edge.
   task automatic step(input logic wr, input logic rd, input logic [DATA_WIDTH-1:0] d,
                       input string tag);
      bit acc_w;
      bit acc_r;
      @(negedge clk);
      wr_en = wr;
      rd_en = rd;
      din   = d;
      acc_w = wr && (sb_q.size() != DEPTH);
      acc_r = rd && (sb_q.size() != 0);
      if (acc_r) exp_dout = sb_q.pop_front();
      if (acc_w) sb_q.push_back(d);
      @(posedge clk);
      #1;
      check_state(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      rst_n = 1'b0;
      sb_q.delete();
      exp_dout = '0;
      #1;
      check_state(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      wr_en = 1'b0;
      rd_en = 1'b0;
      din   = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2 check_state("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Basic ordering
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), "wr4");
      for (int i = 0; i < 4; i++)  step(1'b0, 1'b1, 8'h00, "rd4");

      // Underflow: dout must hold 0x04
      step(1'b0, 1'b1, 8'h00, "underflow");
      step(1'b0, 1'b1, 8'h00, "underflow2");
      step(1'b1, 1'b0, 8'h77, "wr_after_uf");
      step(1'b0, 1'b1, 8'h00, "rd_after_uf");

      // Fill, overflow, simultaneous on full
      for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h10 + i), "fill");
      step(1'b1, 1'b0, 8'hAA, "overflow");
      step(1'b1, 1'b1, 8'h55, "simul_full");
      for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 8'h00, "drain");

      // Simultaneous on empty: write only
      step(1'b1, 1'b1, 8'h3C, "simul_empty");
      step(1'b0, 1'b1, 8'h00, "rd_simul_empty");

      // Half-full simultaneous traffic
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "half_fill");
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'(8'h60 + i), "half_simul");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "half_drain");

      // Pointer wrap
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 8'($urandom_range(255)), "wrap_wr");
         for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, "wrap_rd");
      end

      // Reset mid-stream discards contents
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'hC0 + i), "pre_rst");
      step(1'b0, 1'b1, 8'h00, "pre_rst_rd");
      do_reset("mid_rst");
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'hD0 + i), "post_rst_wr");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, "post_rst_rd");

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
